pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Next-PC generation stage that sits directly upstream of pc_reg. It reads the current PC, which is pc_reg's o_data_out, and computes the next program counter from the control unit's flow commands: increment, jump, relative branch, call and return. It drives the next PC and a write enable into pc_reg's i_data_in and i_we. An internal return-address stack supports subroutine call and return.

Parameters:
WORD_SIZE, 8, width of the PC, target and offset buses.
PC_STEP, 1, sequential increment applied to the current PC.
RESET_VEC, 0, value driven on o_next_pc after reset.
STACK_DEPTH, 4, number of return-address entries; must be ≥1.

Ports:
i_clk  in  1  system clock, rising edge.
i_rst  in  1  reset, synchronous, active-high.
i_pc  in  WORD_SIZE  current PC, from pc_reg o_data_out.
i_stall  in  1  freeze sequencer; no PC update.
i_jmp  in  1  absolute jump to i_target.
i_br_taken  in  1  relative branch by i_offset.
i_call  in  1  push return address, jump to i_target.
i_ret  in  1  pop return address into PC.
i_target  in  WORD_SIZE  absolute destination for jmp and call.
i_offset  in  WORD_SIZE  two's-complement branch displacement.
o_next_pc  out  WORD_SIZE  registered next PC, to pc_reg i_data_in.
o_pc_we  out  1  registered write strobe, to pc_reg i_we.
o_stack_empty  out  1  stack pointer == 0.
o_stack_full  out  1  stack pointer == STACK_DEPTH.
o_err  out  1  sticky stack overflow/underflow flag.

Behaviour:
- All state updates on the rising edge of i_clk; there is no asynchronous path.
- Reset (i_rst=1 at an edge) overrides every other input:
  - o_next_pc=RESET_VEC, o_pc_we=0, sp=0, o_stack_empty=1, o_stack_full=0, o_err=0.
  - Stack RAM contents are not cleared (don't-care).
- Latency: commands and i_pc sampled at edge N appear on o_next_pc/o_pc_we after edge N. Outputs are registered; there are no combinational input-to-output paths.
- Stall (i_stall=1, i_rst=0):
  - o_next_pc holds, o_pc_we=0.
  - sp, stack and o_err are unchanged.
  - All commands are ignored (dropped, not queued).
- Normal cycle (i_rst=0, i_stall=0): o_pc_we=1. Command priority is ret > call > jmp > br_taken > increment. Exactly one action is taken per cycle; lower-priority commands asserted in the same cycle are ignored.
- Increment: next = i_pc + PC_STEP, truncated to WORD_SIZE (wraps, 0xFF→0x00 at 8 bits).
- Jump: next = i_target.
- Branch: next = i_pc + i_offset, with i_offset signed, modulo 2^WORD_SIZE.
- Call:
  - If sp<STACK_DEPTH: stack[sp] = i_pc+PC_STEP, sp=sp+1, next = i_target.
  - If full: no push, sp unchanged, o_err←1, next = i_pc+PC_STEP.
- Return:
  - If sp>0: sp=sp-1, next = stack[sp-1].
  - If empty: no pop, o_err←1, next = i_pc+PC_STEP.
- o_err is sticky and clears only on reset.
- o_stack_empty and o_stack_full are decoded from the registered sp, so they reflect the stack state after the most recent edge.
- Simultaneous call+ret: ret wins, and the call is not pushed.
- Reset mid-operation, with the stack partially filled: sp→0 at that edge, and a subsequent ret is an underflow.

Test Plan:
(WORD_SIZE=8, PC_STEP=1, RESET_VEC=0x00, STACK_DEPTH=4)
1. Reset: i_rst=1 for one edge with i_jmp=1, i_target=0x55 → o_next_pc=0x00, o_pc_we=0, o_stack_empty=1, o_err=0.
2. Increment wrap: i_pc=0x10, no command → 0x11, we=1. Then i_pc=0xFF → 0x00.
3. Branch and priority:
   - i_pc=0x10, i_br_taken=1, i_offset=0xFC → 0x0C.
   - i_offset=0x05 → 0x15.
   - i_jmp=1 and i_br_taken=1, i_target=0x80 → 0x80.
4. Call/return:
   - i_pc=0x20, i_call=1, i_target=0x80 → 0x80, o_stack_empty=0.
   - Next, i_pc=0x85, i_ret=1 → 0x21, o_stack_empty=1.
   - Simultaneous call+ret with empty stack → 0x86 (underflow path), o_err=1, o_stack_empty stays 1.
5. Overflow:
   - Four calls from i_pc=0x00,0x10,0x20,0x30 → o_stack_full=1.
   - Fifth call at i_pc=0x40, target 0x90 → 0x41, o_err=1, sp stays 4.
   - Four rets → 0x31,0x21,0x11,0x01, then o_stack_empty=1.
6. Stall and reset:
   - With o_next_pc=0x21, i_stall=1 plus i_call=1, i_target=0x33 → o_next_pc=0x21, o_pc_we=0, no push.
   - Release stall and push once, then assert i_rst mid-stack → sp=0, o_err=0. A following ret → o_err=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC generation with return-address stack
//
// Computes the next program counter from the control unit's flow commands
// and drives it, with a write strobe, into pc_reg. Command priority is
// ret > call > jmp > br_taken > increment. Exactly one action is taken per
// unstalled cycle. A small return-address stack backs call/ret.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_pc           current PC (pc_reg o_data_out)
//   i_stall        freeze: no PC update, commands dropped
//   i_jmp          absolute jump to i_target
//   i_br_taken     relative branch by signed i_offset
//   i_call         push i_pc+PC_STEP, jump to i_target
//   i_ret          pop return address into PC
//   i_target       absolute destination for jmp/call
//   i_offset       two's-complement branch displacement
//   o_next_pc      registered next PC (pc_reg i_data_in)
//   o_pc_we        registered write strobe (pc_reg i_we)
//   o_stack_empty  stack pointer == 0
//   o_stack_full   stack pointer == STACK_DEPTH
//   o_err          sticky overflow/underflow flag, cleared by reset only

module pc_sequencer #(
    parameter int WORD_SIZE   = 8,
    parameter int PC_STEP     = 1,
    parameter int RESET_VEC   = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WORD_SIZE-1:0] i_pc,
    input  logic                 i_stall,
    input  logic                 i_jmp,
    input  logic                 i_br_taken,
    input  logic                 i_call,
    input  logic                 i_ret,
    input  logic [WORD_SIZE-1:0] i_target,
    input  logic [WORD_SIZE-1:0] i_offset,
    output logic [WORD_SIZE-1:0] o_next_pc,
    output logic                 o_pc_we,
    output logic                 o_stack_empty,
    output logic                 o_stack_full,
    output logic                 o_err
);

    // sp counts 0..STACK_DEPTH inclusive, so it needs one more code than
    // the RAM index does.
    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [SPW-1:0]       DEPTH_SP = SPW'(STACK_DEPTH);
    localparam logic [SPW-1:0]       ONE_SP   = SPW'(1);
    localparam logic [WORD_SIZE-1:0] STEP     = WORD_SIZE'(PC_STEP);
    localparam logic [WORD_SIZE-1:0] RST_PC   = WORD_SIZE'(RESET_VEC);

    logic [WORD_SIZE-1:0] stack_mem [STACK_DEPTH];
    logic [SPW-1:0]       sp;
    logic [SPW-1:0]       sp_dec;
    logic [WORD_SIZE-1:0] pc_inc;

    assign sp_dec = sp - ONE_SP;
    assign pc_inc = i_pc + STEP;

    assign o_stack_empty = (sp == '0);
    assign o_stack_full  = (sp == DEPTH_SP);

    // Stack RAM is deliberately left out of reset; only sp is cleared, so
    // stale entries are unreachable until overwritten by a push.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_next_pc <= RST_PC;
            o_pc_we   <= 1'b0;
            sp        <= '0;
            o_err     <= 1'b0;
        end else if (i_stall) begin
            o_pc_we   <= 1'b0;
        end else begin
            o_pc_we <= 1'b1;
            if (i_ret) begin
                if (sp != '0) begin
                    sp        <= sp_dec;
                    o_next_pc <= stack_mem[sp_dec[IDXW-1:0]];
                end else begin
                    o_err     <= 1'b1;
                    o_next_pc <= pc_inc;
                end
            end else if (i_call) begin
                if (sp < DEPTH_SP) begin
                    stack_mem[sp[IDXW-1:0]] <= pc_inc;
                    sp        <= sp + ONE_SP;
                    o_next_pc <= i_target;
                end else begin
                    o_err     <= 1'b1;
                    o_next_pc <= pc_inc;
                end
            end else if (i_jmp) begin
                o_next_pc <= i_target;
            end else if (i_br_taken) begin
                // Modular add: two's-complement offset needs no sign handling.
                o_next_pc <= i_pc + i_offset;
            end else begin
                o_next_pc <= pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0, stall = 1'b0, jmp = 1'b0, br_taken = 1'b0;
    logic         call = 1'b0, ret = 1'b0;
    logic [W-1:0] pc = '0, target = '0, offset = '0;
    logic [W-1:0] next_pc;
    logic         pc_we, stack_empty, stack_full, err;

    always #5 clk = ~clk;

    pc_sequencer #(
        .WORD_SIZE   (8),
        .PC_STEP     (1),
        .RESET_VEC   (0),
        .STACK_DEPTH (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pc          (pc),
        .i_stall       (stall),
        .i_jmp         (jmp),
        .i_br_taken    (br_taken),
        .i_call        (call),
        .i_ret         (ret),
        .i_target      (target),
        .i_offset      (offset),
        .o_next_pc     (next_pc),
        .o_pc_we       (pc_we),
        .o_stack_empty (stack_empty),
        .o_stack_full  (stack_full),
        .o_err         (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: the return stack is a plain queue, sp is its size.
    logic [W-1:0] ret_q[$];
    logic [W-1:0] m_pc  = '0;
    logic         m_we  = 1'b0;
    logic         m_err = 1'b0;

    task automatic model_edge();
        logic [W-1:0] inc;
        inc = pc + 8'd1;
        if (rst) begin
            ret_q.delete();
            m_pc  = 8'h00;
            m_we  = 1'b0;
            m_err = 1'b0;
        end else if (stall) begin
            m_we = 1'b0;
        end else begin
            m_we = 1'b1;
            if (ret) begin
                if (ret_q.size() > 0) m_pc = ret_q.pop_back();
                else begin m_err = 1'b1; m_pc = inc; end
            end else if (call) begin
                if (ret_q.size() < 4) begin ret_q.push_back(inc); m_pc = target; end
                else begin m_err = 1'b1; m_pc = inc; end
            end else if (jmp) m_pc = target;
            else if (br_taken) m_pc = pc + offset;
            else m_pc = inc;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic j, input logic b,
                        input logic c, input logic rt, input logic [W-1:0] p,
                        input logic [W-1:0] t, input logic [W-1:0] o);
        rst = r; stall = s; jmp = j; br_taken = b; call = c; ret = rt;
        pc = p; target = t; offset = o;
        @(posedge clk);
        model_edge();
        #1;
        check("next_pc", next_pc, m_pc);
        check("pc_we", pc_we, m_we);
        check("empty", stack_empty, ret_q.size() == 0);
        check("full", stack_full, ret_q.size() == 4);
        check("err", err, m_err);
    endtask

    initial begin
        // 1. reset beats a simultaneous jump
        step(1, 0, 1, 0, 0, 0, 8'h00, 8'h55, 8'h00);
        check("tp1_pc", next_pc, 8'h00);
        check("tp1_we", pc_we, 1'b0);
        check("tp1_empty", stack_empty, 1'b1);
        check("tp1_err", err, 1'b0);

        // 2. increment and wrap
        step(0, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00);
        check("tp2_inc", next_pc, 8'h11);
        check("tp2_we", pc_we, 1'b1);
        step(0, 0, 0, 0, 0, 0, 8'hFF, 8'h00, 8'h00);
        check("tp2_wrap", next_pc, 8'h00);

        // 3. branch both directions, jmp beats branch
        step(0, 0, 0, 1, 0, 0, 8'h10, 8'h00, 8'hFC);
        check("tp3_br_neg", next_pc, 8'h0C);
        step(0, 0, 0, 1, 0, 0, 8'h10, 8'h00, 8'h05);
        check("tp3_br_pos", next_pc, 8'h15);
        step(0, 0, 1, 1, 0, 0, 8'h10, 8'h80, 8'h05);
        check("tp3_jmp_prio", next_pc, 8'h80);

        // 4. call, return, call+ret underflow
        step(0, 0, 0, 0, 1, 0, 8'h20, 8'h80, 8'h00);
        check("tp4_call", next_pc, 8'h80);
        check("tp4_call_empty", stack_empty, 1'b0);
        step(0, 0, 0, 0, 0, 1, 8'h85, 8'h00, 8'h00);
        check("tp4_ret", next_pc, 8'h21);
        check("tp4_ret_empty", stack_empty, 1'b1);
        step(0, 0, 0, 0, 1, 1, 8'h85, 8'h40, 8'h00);
        check("tp4_uflow", next_pc, 8'h86);
        check("tp4_uflow_err", err, 1'b1);
        check("tp4_uflow_empty", stack_empty, 1'b1);

        // 5. overflow, then drain
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 1, 0, 8'(i * 16), 8'h90, 8'h00);
        check("tp5_full", stack_full, 1'b1);
        step(0, 0, 0, 0, 1, 0, 8'h40, 8'h90, 8'h00);
        check("tp5_oflow", next_pc, 8'h41);
        check("tp5_oflow_full", stack_full, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            step(0, 0, 0, 0, 0, 1, 8'h90, 8'h00, 8'h00);
            check("tp5_ret", next_pc, 8'(i * 16 + 1));
        end
        check("tp5_drained", stack_empty, 1'b1);

        // 6. stall drops a call; reset mid-stack clears sp and err
        step(0, 0, 1, 0, 0, 0, 8'h00, 8'h21, 8'h00);
        step(0, 1, 0, 0, 1, 0, 8'h21, 8'h33, 8'h00);
        check("tp6_stall_pc", next_pc, 8'h21);
        check("tp6_stall_we", pc_we, 1'b0);
        check("tp6_stall_nopush", stack_empty, 1'b1);
        step(0, 0, 0, 0, 1, 0, 8'h21, 8'h50, 8'h00);
        check("tp6_push", stack_empty, 1'b0);
        step(1, 0, 0, 0, 0, 0, 8'h50, 8'h00, 8'h00);
        check("tp6_rst_empty", stack_empty, 1'b1);
        check("tp6_rst_err", err, 1'b0);
        step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        check("tp6_ret_uflow", err, 1'b1);

        // Randomized traffic, PC mostly fed back as pc_reg would.
        step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            logic [W-1:0] p;
            p = ($urandom_range(0, 7) == 0) ? 8'($urandom) : m_pc;
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0,
                 p, 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
